// File: rtl/axis_fir_decimate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_fir_decimate_pkg
// Purpose  : Shared constants and narrowing helper for axis_fir_decimate.
//            sat_narrow is used only when AXIS_FIR_DECIMATE_SAT_EN is defined.
// Revision : 1.0
// ============================================================================
package axis_fir_decimate_pkg;

  localparam int unsigned FIFO_DEPTH = 2;

  // Full-scale extremes; sat_narrow shifts them down to the requested width.
  localparam logic signed [63:0] OUT_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] OUT_MIN = 64'sh8000_0000_0000_0000;

  function automatic logic [63:0] sat_narrow(input logic signed [63:0] x,
                                             input int unsigned out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = OUT_MAX >>> (64 - out_w);
    lo = OUT_MIN >>> (64 - out_w);
    if (x > hi) begin
      sat_narrow = hi;
    end else if (x < lo) begin
      sat_narrow = lo;
    end else begin
      sat_narrow = x;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fir_decimate_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : axis_fir_decimate_fifo2
// Purpose  : Two-entry register FIFO; a push while full is accepted only when
//            a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module axis_fir_decimate_fifo2
  import axis_fir_decimate_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign o_empty = (count_q == '0);
  assign o_data  = head_q;

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10: begin
        if (o_empty) head_d = i_data;
        else         tail_d = i_data;
        count_d = count_q + CNT_W'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - CNT_W'(1);
      end
      2'b11: begin
        // Occupancy is unchanged; with one entry the new data lands at the head.
        if (count_q == CNT_W'(1)) begin
          head_d = i_data;
        end else begin
          head_d = tail_q;
          tail_d = i_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_fir_decimate.sv
`default_nettype none
// ============================================================================
// Module   : axis_fir_decimate
// Purpose  : Keeps every DECIM-th valid FIR sample, scales/narrows it and
//            queues it on an AXI-stream master. Optional AXIS_FIR_DECIMATE_SAT_EN
//            selects saturating narrowing (default: wrap).
// Revision : 1.0
// ============================================================================
module axis_fir_decimate
  import axis_fir_decimate_pkg::*;
#(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MAXIS_TDATA_WIDTH = 16,
  parameter int DECIM             = 64,
  parameter int DECIM_L           = 6,
  parameter int SHIFT             = 0
) (
  input  logic                         a_clk,
  input  logic                         a_resetn,
  input  logic                         next_dv,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                         S_AXIS_tvalid,
  output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                         M_AXIS_tvalid,
  input  logic                         M_AXIS_tready,
  output logic [DECIM_L-1:0]           decim_phase,
  output logic [15:0]                  overflow_count
);

  logic                                next_dv_q, next_dv_d;
  logic [DECIM_L-1:0]                  phase_q, phase_d;
  logic [MAXIS_TDATA_WIDTH-1:0]        data1_q, data1_d;
  logic                                v1_q, v1_d;
  logic [15:0]                         ovf_q, ovf_d;

  logic                                w_strobe;
  logic                                w_pop;
  logic                                w_full;
  logic                                w_empty;
  logic                                w_drop;
  logic signed [SAXIS_TDATA_WIDTH-1:0] w_x;
  logic [MAXIS_TDATA_WIDTH-1:0]        w_narrow;

  assign w_strobe = next_dv & ~next_dv_q;
  assign w_x      = $signed(S_AXIS_tdata) >>> SHIFT;

`ifdef AXIS_FIR_DECIMATE_SAT_EN
  assign w_narrow = MAXIS_TDATA_WIDTH'(sat_narrow(64'(w_x), MAXIS_TDATA_WIDTH));
`else
  assign w_narrow = MAXIS_TDATA_WIDTH'(w_x);
`endif

  assign M_AXIS_tvalid  = ~w_empty;
  assign w_pop          = M_AXIS_tvalid & M_AXIS_tready;
  assign w_drop         = v1_q & w_full & ~w_pop;
  assign decim_phase    = phase_q;
  assign overflow_count = ovf_q;

  always_comb begin
    next_dv_d = next_dv;
    phase_d   = phase_q;
    data1_d   = data1_q;
    v1_d      = 1'b0;
    ovf_d     = ovf_q;
    if (w_strobe) begin
      if (S_AXIS_tvalid) begin
        if (phase_q == DECIM_L'(DECIM - 1)) begin
          phase_d = '0;
          data1_d = w_narrow;
          v1_d    = 1'b1;
        end else begin
          phase_d = phase_q + DECIM_L'(1);
        end
      end else begin
        // An invalid strobe means the FIR restarted its sum; realign with it.
        phase_d = '0;
      end
    end
    if (w_drop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      next_dv_q <= 1'b0;
      phase_q   <= '0;
      data1_q   <= '0;
      v1_q      <= 1'b0;
      ovf_q     <= '0;
    end else begin
      next_dv_q <= next_dv_d;
      phase_q   <= phase_d;
      data1_q   <= data1_d;
      v1_q      <= v1_d;
      ovf_q     <= ovf_d;
    end
  end

  axis_fir_decimate_fifo2 #(
    .WIDTH (MAXIS_TDATA_WIDTH)
  ) u_fifo (
    .clk     (a_clk),
    .rst_n   (a_resetn),
    .i_push  (v1_q),
    .i_pop   (w_pop),
    .i_data  (data1_q),
    .o_data  (M_AXIS_tdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_axis_fir_decimate.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_fir_decimate
// Purpose  : Directed stimulus with a transaction-level reference model for
//            axis_fir_decimate (DECIM=4, SHIFT=0, 32->16 bit).
// Revision : 1.0
// ============================================================================
module tb_axis_fir_decimate;

  localparam int DECIM   = 4;
  localparam int DECIM_L = 2;
  localparam int SHIFT   = 0;

  logic        a_clk         = 1'b0;
  logic        a_resetn      = 1'b0;
  logic        next_dv       = 1'b0;
  logic [31:0] S_AXIS_tdata  = '0;
  logic        S_AXIS_tvalid = 1'b0;
  logic        M_AXIS_tready = 1'b1;
  logic [15:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic [1:0]  decim_phase;
  logic [15:0] overflow_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] delivered[$];
  logic [15:0] exp_q[$];

  bit          m_prev;
  int          m_cnt;
  bit          m_pend;
  logic [15:0] m_val;
  logic [15:0] m_fifo[$];
  int          m_ovf;

  axis_fir_decimate #(
    .SAXIS_TDATA_WIDTH (32),
    .MAXIS_TDATA_WIDTH (16),
    .DECIM             (DECIM),
    .DECIM_L           (DECIM_L),
    .SHIFT             (SHIFT)
  ) dut (
    .a_clk          (a_clk),
    .a_resetn       (a_resetn),
    .next_dv        (next_dv),
    .S_AXIS_tdata   (S_AXIS_tdata),
    .S_AXIS_tvalid  (S_AXIS_tvalid),
    .M_AXIS_tdata   (M_AXIS_tdata),
    .M_AXIS_tvalid  (M_AXIS_tvalid),
    .M_AXIS_tready  (M_AXIS_tready),
    .decim_phase    (decim_phase),
    .overflow_count (overflow_count)
  );

  always #5 a_clk = ~a_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] exp_scale(input logic [31:0] d);
    longint x;
    x = longint'($signed(d)) >>> SHIFT;
`ifdef AXIS_FIR_DECIMATE_SAT_EN
    if (x > 32767)  return 16'h7FFF;
    if (x < -32768) return 16'h8000;
`endif
    return x[15:0];
  endfunction

  // Reference model: counts valid strobes, a kept sample reaches the queue
  // one edge after its strobe, queue holds two, extra arrivals are dropped.
  task automatic model_step();
    bit pop;
    pop = (m_fifo.size() != 0) && M_AXIS_tready;
    if (pop) void'(m_fifo.pop_front());
    if (m_pend) begin
      if (m_fifo.size() >= 2) m_ovf = (m_ovf == 65535) ? 65535 : m_ovf + 1;
      else m_fifo.push_back(m_val);
    end
    m_pend = 1'b0;
    if (next_dv && !m_prev) begin
      if (S_AXIS_tvalid) begin
        m_cnt++;
        if (m_cnt == DECIM) begin
          m_cnt  = 0;
          m_pend = 1'b1;
          m_val  = exp_scale(S_AXIS_tdata);
        end
      end else begin
        m_cnt = 0;
      end
    end
    m_prev = next_dv;
  endtask

  initial forever begin
    @(posedge a_clk or negedge a_resetn);
    if (!a_resetn) begin
      m_prev = 1'b0;
      m_cnt  = 0;
      m_pend = 1'b0;
      m_fifo.delete();
      m_ovf  = 0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(posedge a_clk);
    #2;
    chk("model_tvalid", 32'(M_AXIS_tvalid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) chk("model_tdata", 32'(M_AXIS_tdata), 32'(m_fifo[0]));
    chk("model_phase", 32'(decim_phase), 32'(m_cnt));
    chk("model_ovf", 32'(overflow_count), 32'(m_ovf));
  end

  // Record each accepted beat using the values present before the popping edge.
  initial forever begin
    @(negedge a_clk);
    #1;
    if (a_resetn && M_AXIS_tvalid && M_AXIS_tready) delivered.push_back(M_AXIS_tdata);
  end

  task automatic strobe(input logic [31:0] d, input logic v);
    @(negedge a_clk);
    next_dv       = 1'b1;
    S_AXIS_tdata  = d;
    S_AXIS_tvalid = v;
    @(negedge a_clk);
    next_dv = 1'b0;
  endtask

  task automatic group(input logic [31:0] val);
    for (int k = 0; k < DECIM - 1; k++) strobe(32'd0, 1'b1);
    strobe(val, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge a_clk);
  endtask

  task automatic do_reset();
    @(negedge a_clk);
    a_resetn = 1'b0;
    next_dv  = 1'b0;
    @(negedge a_clk);
    a_resetn = 1'b1;
    delivered.delete();
  endtask

  task automatic chk_delivered(input string name);
    chk({name, "_count"}, 32'(delivered.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++) begin
      chk(name, (j < delivered.size()) ? 32'(delivered[j]) : 32'hDEAD_BEEF, 32'(exp_q[j]));
    end
  endtask

  initial begin
    repeat (3) @(negedge a_clk);
    chk("rst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    chk("rst_tdata", 32'(M_AXIS_tdata), 32'd0);
    chk("rst_phase", 32'(decim_phase), 32'd0);
    chk("rst_ovf", 32'(overflow_count), 32'd0);
    a_resetn      = 1'b1;
    M_AXIS_tready = 1'b1;

    // Inputs 1..12, every fourth kept, 2-cycle latency.
    for (int i = 1; i <= 12; i++) begin
      strobe(32'(i), 1'b1);
      if (i % DECIM == 0) begin
        chk("lat_n_tvalid", 32'(M_AXIS_tvalid), 32'd0);
        @(posedge a_clk);
        #2;
        chk("lat_n1_tvalid", 32'(M_AXIS_tvalid), 32'd1);
        chk("lat_n1_tdata", 32'(M_AXIS_tdata), 32'(i));
      end
    end
    idle(4);
    exp_q = {16'd4, 16'd8, 16'd12};
    chk_delivered("t1_out");

    // Narrowing of large positive and negative values.
    do_reset();
    group(32'h0001_2345);
    group(32'hFFFE_0000);
    idle(4);
`ifdef AXIS_FIR_DECIMATE_SAT_EN
    exp_q = {16'h7FFF, 16'h8000};
`else
    exp_q = {16'h2345, 16'h0000};
`endif
    chk_delivered("t2_scale");

    // Back-pressure across four captures.
    do_reset();
    M_AXIS_tready = 1'b0;
    group(32'd100);
    group(32'd200);
    group(32'd300);
    group(32'd400);
    idle(3);
    chk("t3_ovf", 32'(overflow_count), 32'd2);
    chk("t3_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    chk("t3_tdata", 32'(M_AXIS_tdata), 32'd100);
    M_AXIS_tready = 1'b1;
    idle(5);
    exp_q = {16'd100, 16'd200};
    chk_delivered("t3_out");
    chk("t3_drained", 32'(M_AXIS_tvalid), 32'd0);
    chk("t3_ovf_hold", 32'(overflow_count), 32'd2);

    // Push and pop on the same edge while full.
    do_reset();
    M_AXIS_tready = 1'b0;
    group(32'd10);
    group(32'd20);
    idle(2);
    chk("t4_full_tdata", 32'(M_AXIS_tdata), 32'd10);
    for (int k = 0; k < DECIM - 1; k++) strobe(32'd0, 1'b1);
    @(negedge a_clk);
    next_dv       = 1'b1;
    S_AXIS_tdata  = 32'd30;
    S_AXIS_tvalid = 1'b1;
    @(negedge a_clk);
    next_dv       = 1'b0;
    M_AXIS_tready = 1'b1;
    @(negedge a_clk);
    M_AXIS_tready = 1'b0;
    chk("t4_ovf", 32'(overflow_count), 32'd0);
    chk("t4_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    chk("t4_tdata", 32'(M_AXIS_tdata), 32'd20);
    M_AXIS_tready = 1'b1;
    idle(5);
    exp_q = {16'd10, 16'd20, 16'd30};
    chk_delivered("t4_out");

    // Invalid strobe clears the phase.
    do_reset();
    strobe(32'd1, 1'b1);
    strobe(32'd2, 1'b1);
    chk("t5_phase2", 32'(decim_phase), 32'd2);
    strobe(32'd0, 1'b0);
    chk("t5_phase0", 32'(decim_phase), 32'd0);
    strobe(32'd5, 1'b1);
    strobe(32'd6, 1'b1);
    strobe(32'd7, 1'b1);
    chk("t5_phase3", 32'(decim_phase), 32'd3);
    chk("t5_no_out", 32'(M_AXIS_tvalid), 32'd0);
    strobe(32'd8, 1'b1);
    idle(3);
    exp_q = {16'd8};
    chk_delivered("t5_out");

    // Level-high next_dv counts once.
    do_reset();
    @(negedge a_clk);
    next_dv       = 1'b1;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = 32'd0;
    idle(5);
    next_dv = 1'b0;
    idle(1);
    chk("t6_one_step", 32'(decim_phase), 32'd1);

    // Asynchronous reset with a full FIFO.
    do_reset();
    M_AXIS_tready = 1'b0;
    group(32'd11);
    group(32'd22);
    group(32'd33);
    idle(3);
    chk("t7_pre_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    chk("t7_pre_ovf", 32'(overflow_count), 32'd1);
    @(negedge a_clk);
    #1;
    a_resetn = 1'b0;
    #1;
    chk("t7_rst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    chk("t7_rst_phase", 32'(decim_phase), 32'd0);
    chk("t7_rst_ovf", 32'(overflow_count), 32'd0);
    chk("t7_rst_tdata", 32'(M_AXIS_tdata), 32'd0);
    @(negedge a_clk);
    a_resetn = 1'b1;
    idle(2);
    chk("t7_post_tvalid", 32'(M_AXIS_tvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_fir_decimate.md
# axis_fir_decimate

Decimating output stage directly downstream of the boxcar moving-average FIR. Keeps every DECIM-th valid FIR output (one per `next_dv` sample event), arithmetically scales and narrows it to the output width, and presents it on a back-pressurable AXI-stream master through a 2-entry FIFO. Overflows are counted rather than stalling the upstream FIR, which cannot be stalled.

## Interface
Parameters:
- SAXIS_TDATA_WIDTH, 32, width of the signed FIR output sample.
- MAXIS_TDATA_WIDTH, 16, width of the signed decimated output sample.
- DECIM, 64, decimation ratio; must be ≥ 2.
- DECIM_L, 6, phase counter width; 2^DECIM_L ≥ DECIM.
- SHIFT, 0, arithmetic right shift applied before narrowing; range 0..SAXIS_TDATA_WIDTH-1.

Ports:
- a_clk  in  1  single clock; all logic is on its rising edge.
- a_resetn  in  1  asynchronous, active-low reset.
- next_dv  in  1  sample-event signal, synchronous to a_clk; one event per rising edge.
- S_AXIS_tdata  in  SAXIS_TDATA_WIDTH  signed FIR output.
- S_AXIS_tvalid  in  1  FIR output valid; there is no tready, so the upstream FIR is never stalled.
- M_AXIS_tdata  out  MAXIS_TDATA_WIDTH  decimated sample, valid at the FIFO head.
- M_AXIS_tvalid  out  1  FIFO not empty.
- M_AXIS_tready  in  1  downstream accept.
- decim_phase  out  DECIM_L  current phase counter.
- overflow_count  out  16  number of dropped samples; saturates at 0xFFFF.

## Operation
- Strobe: `strobe = next_dv & ~next_dv_q`. `next_dv_q` is registered and resets to 0, so if `next_dv` is high when reset releases, a strobe fires on the first cycle.
- When `strobe` and `S_AXIS_tvalid` are both 1:
  - If phase == DECIM-1, phase goes to 0 and the sample is captured into stage 1.
  - Otherwise phase increments.
- When `strobe` is 1 and `S_AXIS_tvalid` is 0, phase goes to 0. This matches the FIR clearing its sum. Nothing is captured.
- Cycles without a strobe leave all state unchanged, except the FIFO pop path.
- Scale: `x = S_AXIS_tdata >>> SHIFT` (sign-preserving), then narrowed to MAXIS_TDATA_WIDTH. Narrowing behaviour is set under Configuration.
- The stage-1 register holds the value plus a `v1` flag.
- When `v1` = 1, the value is pushed into the FIFO on the next edge. `v1` clears that same edge.
- FIFO holds 2 entries, first in first out. Pop occurs when `M_AXIS_tvalid & M_AXIS_tready`.
- Push when FIFO is full and there is no pop in the same cycle: the new sample is dropped and `overflow_count` increments (saturating). FIFO contents are unchanged.
- Push and pop in the same cycle while full: both happen, nothing is dropped, and the occupancy stays at 2.
- Push and pop in the same cycle while empty: not possible, because `M_AXIS_tvalid` is 0.
- Reset values, all 0: `M_AXIS_tvalid`, `M_AXIS_tdata`, `decim_phase`, `overflow_count`, FIFO occupancy, `v1`, `next_dv_q`.
- Reset asserted mid-operation discards all buffered samples immediately (asynchronous reset).

## Timing
- Capturing strobe sampled at edge N: `v1` = 1 after N, FIFO write at edge N+1, `M_AXIS_tvalid` = 1 in the cycle after N+1. Latency is 2 cycles.
- `M_AXIS_tdata` is stable while `M_AXIS_tvalid` is 1 and `M_AXIS_tready` is 0.
- `M_AXIS_tvalid` does not drop without a pop.
- Sustained throughput: one output per DECIM strobes. The FIFO absorbs up to 2 samples of back-pressure.

## Configuration
- AXIS_FIR_DECIMATE_SAT_EN:
  - Defined: narrowing saturates. Values above the output maximum become 0x7FFF…; values below the minimum become 0x8000….
  - Undefined: narrowing takes the low MAXIS_TDATA_WIDTH bits of `x` (wraps). This removes the compare logic.

## Structure
- Package `axis_fir_decimate_pkg` holds:
  - the `sat_narrow` function, with widths as arguments;
  - the output extreme constants (OUT_MAX, OUT_MIN);
  - the FIFO depth constant, 2.
- Sub-module `axis_fir_decimate_fifo2`: 2-entry register FIFO with push/pop/full/empty and same-cycle push+pop when full. Phase, strobe and scale logic stay in the top level.

## Test plan
- DECIM=4, SHIFT=0, `M_AXIS_tready`=1; drive inputs 1..12, one per strobe -> outputs 4, 8, 12, each 2 cycles after its strobe.
- SAT_EN defined, SHIFT=0, input 0x00012345 on the capture phase -> output 0x7FFF; input 0xFFFE0000 -> output 0x8000. SAT_EN undefined -> outputs 0x2345 and 0x0000.
- `M_AXIS_tready`=0 across 4 capture events -> FIFO holds the first 2; `overflow_count`=2. Raise tready -> exactly those 2 samples are delivered in order.
- FIFO full, capture push and pop in the same cycle -> no drop, `overflow_count` unchanged, order preserved.
- `S_AXIS_tvalid`=0 on a strobe at phase 2 -> `decim_phase`=0; the next capture happens DECIM valid strobes later.
- `next_dv` held high for 5 cycles -> exactly one phase step. Assert `a_resetn` while the FIFO holds 2 entries -> `M_AXIS_tvalid`=0 immediately; `decim_phase` and `overflow_count` read 0.
